// File: rtl/irq_ack_sequencer.sv
// -----------------------------------------------------------------------------
// irq_ack_sequencer
//
// Acknowledge sequencer for a vector interrupt controller. A synchronized irq
// is confirmed over two cycles. The block then drives an active-low inta pulse
// of programmable length. On the last pulse cycle it captures the controller's
// vector into a one-entry valid/ready holding register. A programmable
// recovery gap follows, so the controller has time to drop irq. All state
// advances on the falling edge of sclk.
//
// Optional build macro:
//   IRQ_ACK_STATS_EN - when defined, 8-bit saturating ack and spurious
//                      counters are built. They are cleared by a write to
//                      address 1. When undefined, no counter flops exist and
//                      dout[31:16] reads 0.
//
// Ports:
//   sclk       in   1  system clock, state updates on negedge
//   nrst       in   1  asynchronous active-low reset
//   pre_wen    in   1  write strobe, one cycle ahead of di
//   pre_wa     in   1  write address: 0 = control, 1 = clear counters
//   di         in  16  write data: [0] enable, [7:4] pulse_len, [11:8] holdoff
//   irq        in   1  interrupt request, active high, asynchronous
//   irqv       in   8  interrupt vector from the controller
//   inta       out  1  interrupt acknowledge, active low, registered
//   vect       out  8  acknowledged vector
//   vect_valid out  1  vect holds an unread vector
//   vect_rdy   in   1  consumer ready (transfer when vect_valid & vect_rdy)
//   dout       out 32  status: [7:0] vect, [8] vect_valid, [11:9] state,
//                      [12] enable, [23:16] ack count, [31:24] spurious count
//                      (named dout because "do" is a SystemVerilog keyword)
// -----------------------------------------------------------------------------
module irq_ack_sequencer (
    input  logic        sclk,
    input  logic        nrst,
    input  logic        pre_wen,
    input  logic        pre_wa,
    input  logic [15:0] di,
    input  logic        irq,
    input  logic [7:0]  irqv,
    output logic        inta,
    output logic [7:0]  vect,
    output logic        vect_valid,
    input  logic        vect_rdy,
    output logic [31:0] dout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    // write pipeline and control registers
    logic       wen_d_r;
    logic       wa_d_r;
    logic       enable_r;
    logic [3:0] pulse_len_r;
    logic [3:0] holdoff_r;

    // irq synchronizer
    logic       irq_meta_r;
    logic       irq_s;

    // sequencer
    state_t     state_r;
    logic [3:0] cnt_r;
    logic       inta_r;
    logic [7:0] vect_r;
    logic       vect_valid_r;

    // decoded strobes
    logic       ctrl_we_s;
    logic       xfer_s;
    logic       latch_s;
    logic [3:0] hold_eff_s;
    logic [7:0] ack_cnt_s;
    logic [7:0] spur_cnt_s;
    logic       unused_di_s;

    // Control data bits with no assigned meaning.
    assign unused_di_s = ^{di[15:12], di[3:1]};

    // Write decode, handshake, latch strobe and holdoff floor.
    always_comb begin
        ctrl_we_s  = 1'b0;
        xfer_s     = 1'b0;
        latch_s    = 1'b0;
        hold_eff_s = holdoff_r;
        if (wen_d_r && !wa_d_r) begin
            ctrl_we_s = 1'b1;
        end else begin
            ctrl_we_s = 1'b0;
        end
        xfer_s  = vect_valid_r & vect_rdy;
        latch_s = (state_r == ST_ASSERT) && (cnt_r == 4'd0);
        // Recovery is never shorter than 8 cycles, so the controller has time to drop irq.
        if (holdoff_r < 4'd7) begin
            hold_eff_s = 4'd7;
        end else begin
            hold_eff_s = holdoff_r;
        end
    end

    // Delay the write strobe and address by one cycle to line up with di.
    always_ff @(negedge sclk or negedge nrst) begin
        if (!nrst) begin
            wen_d_r <= 1'b0;
            wa_d_r  <= 1'b0;
        end else begin
            wen_d_r <= pre_wen;
            wa_d_r  <= pre_wa;
        end
    end

    // Control register: enable, pulse length and holdoff.
    always_ff @(negedge sclk or negedge nrst) begin
        if (!nrst) begin
            enable_r    <= 1'b0;
            pulse_len_r <= 4'd7;
            holdoff_r   <= 4'd7;
        end else if (ctrl_we_s) begin
            enable_r    <= di[0];
            pulse_len_r <= di[7:4];
            holdoff_r   <= di[11:8];
        end
    end

    // Two-flop synchronizer for the asynchronous irq input.
    always_ff @(negedge sclk or negedge nrst) begin
        if (!nrst) begin
            irq_meta_r <= 1'b0;
            irq_s      <= 1'b0;
        end else begin
            irq_meta_r <= irq;
            irq_s      <= irq_meta_r;
        end
    end

    // Sequencer FSM; inta is a flop so the pulse is glitch-free and async reset forces it high.
    always_ff @(negedge sclk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            inta_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    inta_r <= 1'b1;
                    // An unread vector blocks a new acknowledge unless it is taken this cycle.
                    if (enable_r && irq_s && (!vect_valid_r || xfer_s)) begin
                        state_r <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    // Enable is not rechecked: a confirmed request always completes.
                    if (irq_s) begin
                        state_r <= ST_ASSERT;
                        cnt_r   <= pulse_len_r;
                        inta_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_RECOVER;
                        cnt_r   <= hold_eff_s;
                        inta_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                    inta_r  <= 1'b1;
                end
            endcase
        end
    end

    // Vector holding register; a latch wins over a simultaneous transfer.
    always_ff @(negedge sclk or negedge nrst) begin
        if (!nrst) begin
            vect_r       <= 8'h00;
            vect_valid_r <= 1'b0;
        end else if (latch_s) begin
            vect_r       <= irqv;
            vect_valid_r <= 1'b1;
        end else if (xfer_s) begin
            vect_valid_r <= 1'b0;
        end
    end

`ifdef IRQ_ACK_STATS_EN
    logic       clr_s;
    logic       spur_inc_s;
    logic [7:0] ack_cnt_r;
    logic [7:0] spur_cnt_r;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc = 8'hFF;
        end else begin
            sat_inc = v + 8'd1;
        end
    endfunction

    assign clr_s      = wen_d_r & wa_d_r;
    assign spur_inc_s = (state_r == ST_SYNC) & ~irq_s;

    // Ack counter; a clear takes priority over a same-cycle increment.
    always_ff @(negedge sclk or negedge nrst) begin
        if (!nrst) begin
            ack_cnt_r <= 8'h00;
        end else if (clr_s) begin
            ack_cnt_r <= 8'h00;
        end else if (latch_s) begin
            ack_cnt_r <= sat_inc(ack_cnt_r);
        end
    end

    // Spurious counter: irq dropped before it was confirmed.
    always_ff @(negedge sclk or negedge nrst) begin
        if (!nrst) begin
            spur_cnt_r <= 8'h00;
        end else if (clr_s) begin
            spur_cnt_r <= 8'h00;
        end else if (spur_inc_s) begin
            spur_cnt_r <= sat_inc(spur_cnt_r);
        end
    end

    assign ack_cnt_s  = ack_cnt_r;
    assign spur_cnt_s = spur_cnt_r;
`else
    assign ack_cnt_s  = 8'h00;
    assign spur_cnt_s = 8'h00;
`endif

    assign inta       = inta_r;
    assign vect       = vect_r;
    assign vect_valid = vect_valid_r;
    assign dout       = {spur_cnt_s, ack_cnt_s, 3'b000, enable_r,
                         1'b0, state_r, vect_valid_r, vect_r};

endmodule

// File: tb/tb_irq_ack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irq_ack_sequencer
//
// Self-checking bench for irq_ack_sequencer. The DUT acts on negedge sclk.
// The bench drives inputs and samples outputs on posedge sclk. Expected
// vectors are queued when a request is raised. They are popped and compared
// when the DUT offers them (vect_valid & vect_rdy seen on a sample edge).
// -----------------------------------------------------------------------------
module tb_irq_ack_sequencer;

    logic        sclk = 1'b0;
    logic        nrst = 1'b1;
    logic        pre_wen = 1'b0;
    logic        pre_wa = 1'b0;
    logic [15:0] di = 16'h0000;
    logic        irq = 1'b0;
    logic [7:0]  irqv = 8'h00;
    logic        inta;
    logic [7:0]  vect;
    logic        vect_valid;
    logic        vect_rdy = 1'b0;
    logic [31:0] dout;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 sclk = ~sclk;

    irq_ack_sequencer dut (
        .sclk       (sclk),
        .nrst       (nrst),
        .pre_wen    (pre_wen),
        .pre_wa     (pre_wa),
        .di         (di),
        .irq        (irq),
        .irqv       (irqv),
        .inta       (inta),
        .vect       (vect),
        .vect_valid (vect_valid),
        .vect_rdy   (vect_rdy),
        .dout       (dout)
    );

    task automatic do_reset();
        nrst = 1'b0; pre_wen = 1'b0; pre_wa = 1'b0; di = 16'h0000;
        irq = 1'b0; irqv = 8'h00; vect_rdy = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge sclk);
        nrst = 1'b1;
        @(posedge sclk);
    endtask

    // pre_wen in one cycle, data in the next; the register updates on the negedge of the data cycle.
    task automatic write_reg(input logic a, input logic [15:0] d);
        pre_wen = 1'b1; pre_wa = a;
        @(posedge sclk);
        pre_wen = 1'b0; di = d;
        @(posedge sclk);
        di = 16'h0000; pre_wa = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        nrst = 1'b0;
        #1;
        checks++; if (inta !== 1'b1) begin errors++; $display("FAIL reset_inta got %b exp 1", inta); end
        checks++; if (vect !== 8'h00) begin errors++; $display("FAIL reset_vect got %h exp 00", vect); end
        checks++; if (vect_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", vect_valid); end
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h exp 00000000", dout); end
        repeat (2) @(posedge sclk);
        nrst = 1'b1;
        repeat (2) @(posedge sclk);
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_release_dout got %h exp 00000000", dout); end
    endtask

    task automatic test_basic();
        int n; int lo; int hi; logic [7:0] e;
        do_reset();
        irqv = 8'h5A; vect_rdy = 1'b1;
        write_reg(1'b0, 16'h0771);
        irq = 1'b1;
        exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
        n = 0;
        while (inta !== 1'b0 && n < 30) begin @(posedge sclk); n++; end
        checks++; if (inta !== 1'b0) begin errors++; $display("FAIL basic_start inta got %b exp 0 within 30", inta); end
        lo = 0;
        while (inta === 1'b0 && lo < 30) begin lo++; @(posedge sclk); end
        checks++; if (lo != 8) begin errors++; $display("FAIL basic_low_len got %0d exp 8", lo); end
        checks++; if (vect_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", vect_valid); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL basic_vect1 queue empty"); end
        else begin e = exp_q.pop_front(); if (vect !== e) begin errors++; $display("FAIL basic_vect1 got %h exp %h", vect, e); end end
        // recover 8 cycles, then one IDLE and one SYNC cycle
        hi = 0;
        while (inta === 1'b1 && hi < 30) begin hi++; @(posedge sclk); end
        checks++; if (hi != 10) begin errors++; $display("FAIL basic_gap got %0d exp 10", hi); end
        lo = 0;
        while (inta === 1'b0 && lo < 30) begin lo++; @(posedge sclk); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL basic_vect2 queue empty"); end
        else begin e = exp_q.pop_front(); if (vect !== e) begin errors++; $display("FAIL basic_vect2 got %h exp %h", vect, e); end end
        irq = 1'b0;
        repeat (12) @(posedge sclk);
        checks++; if (dout[11:8] !== 4'h0) begin errors++; $display("FAIL basic_idle state/valid got %h exp 0", dout[11:8]); end
`ifdef IRQ_ACK_STATS_EN
        checks++; if (dout[23:16] !== 8'd2) begin errors++; $display("FAIL basic_ackcnt got %0d exp 2", dout[23:16]); end
`else
        checks++; if (dout[31:16] !== 16'h0) begin errors++; $display("FAIL basic_stats_off got %h exp 0", dout[31:16]); end
`endif
    endtask

    task automatic test_glitch();
        int lows; logic [2:0] st1; logic [2:0] st_end;
        do_reset();
        vect_rdy = 1'b1;
        write_reg(1'b0, 16'h0771);
        @(posedge sclk); irq = 1'b1;
        @(posedge sclk); irq = 1'b0;
        lows = 0; st1 = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge sclk);
            if (inta === 1'b0) lows++;
            if (i == 1) st1 = dout[11:9];
        end
        st_end = dout[11:9];
        checks++; if (st1 !== 3'd1) begin errors++; $display("FAIL glitch_sync state got %0d exp 1", st1); end
        checks++; if (st_end !== 3'd0) begin errors++; $display("FAIL glitch_idle state got %0d exp 0", st_end); end
        for (int i = 0; i < 10; i++) begin @(posedge sclk); if (inta === 1'b0) lows++; end
        checks++; if (lows != 0) begin errors++; $display("FAIL glitch_inta low cycles got %0d exp 0", lows); end
`ifdef IRQ_ACK_STATS_EN
        checks++; if (dout[31:16] !== 16'h0100) begin errors++; $display("FAIL glitch_counts got %h exp 0100", dout[31:16]); end
`else
        checks++; if (dout[31:16] !== 16'h0) begin errors++; $display("FAIL glitch_stats_off got %h exp 0", dout[31:16]); end
`endif
    endtask

    task automatic test_backpressure();
        int n; int lo; int lows; logic [7:0] e;
        do_reset();
        irqv = 8'hA5; vect_rdy = 1'b0;
        write_reg(1'b0, 16'h0771);
        irq = 1'b1; exp_q.push_back(8'hA5);
        n = 0;
        while (inta !== 1'b0 && n < 30) begin @(posedge sclk); n++; end
        lo = 0;
        while (inta === 1'b0 && lo < 30) begin lo++; @(posedge sclk); end
        checks++; if (lo != 8) begin errors++; $display("FAIL bp_low_len got %0d exp 8", lo); end
        lows = 0;
        for (int i = 0; i < 30; i++) begin @(posedge sclk); if (inta === 1'b0) lows++; end
        checks++; if (lows != 0) begin errors++; $display("FAIL bp_hold low cycles got %0d exp 0", lows); end
        checks++; if (dout[11:8] !== 4'h1) begin errors++; $display("FAIL bp_state_valid got %h exp 1", dout[11:8]); end
        irqv = 8'h3C; exp_q.push_back(8'h3C);
        vect_rdy = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_vect1 queue empty"); end
        else begin e = exp_q.pop_front(); if (vect !== e) begin errors++; $display("FAIL bp_vect1 got %h exp %h", vect, e); end end
        // transfer cycle, SYNC cycle, then inta low: two sample edges after vect_rdy rises
        @(posedge sclk); n = 1;
        while (inta !== 1'b0 && n < 10) begin @(posedge sclk); n++; end
        checks++; if (n != 2) begin errors++; $display("FAIL bp_restart got %0d exp 2", n); end
        lo = 0;
        while (inta === 1'b0 && lo < 30) begin lo++; @(posedge sclk); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_vect2 queue empty"); end
        else begin e = exp_q.pop_front(); if (vect !== e || vect_valid !== 1'b1) begin errors++; $display("FAIL bp_vect2 got %h/%b exp %h/1", vect, vect_valid, e); end end
        irq = 1'b0;
        repeat (12) @(posedge sclk);
    endtask

    task automatic test_config_latch();
        int n; int lo; int hi; logic [7:0] e;
        do_reset();
        irqv = 8'h11; vect_rdy = 1'b1;
        write_reg(1'b0, 16'h0311);
        irq = 1'b1;
        exp_q.push_back(8'h11); exp_q.push_back(8'h11); exp_q.push_back(8'h11);
        n = 0;
        while (inta !== 1'b0 && n < 30) begin @(posedge sclk); n++; end
        lo = 0;
        fork
            write_reg(1'b0, 16'h0A51);
            begin
                while (inta === 1'b0 && lo < 30) begin lo++; @(posedge sclk); end
            end
        join
        checks++; if (lo != 2) begin errors++; $display("FAIL cfg_low_old got %0d exp 2", lo); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL cfg_vect1 queue empty"); end
        else begin e = exp_q.pop_front(); if (vect !== e) begin errors++; $display("FAIL cfg_vect1 got %h exp %h", vect, e); end end
        // old holdoff 3 is floored to 7: 8 recover + IDLE + SYNC
        hi = 0;
        while (inta === 1'b1 && hi < 30) begin hi++; @(posedge sclk); end
        checks++; if (hi != 10) begin errors++; $display("FAIL cfg_gap_old got %0d exp 10", hi); end
        lo = 0;
        while (inta === 1'b0 && lo < 30) begin lo++; @(posedge sclk); end
        checks++; if (lo != 6) begin errors++; $display("FAIL cfg_low_new got %0d exp 6", lo); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL cfg_vect2 queue empty"); end
        else begin e = exp_q.pop_front(); if (vect !== e) begin errors++; $display("FAIL cfg_vect2 got %h exp %h", vect, e); end end
        hi = 0;
        while (inta === 1'b1 && hi < 30) begin hi++; @(posedge sclk); end
        checks++; if (hi != 13) begin errors++; $display("FAIL cfg_gap_new got %0d exp 13", hi); end
        lo = 0;
        while (inta === 1'b0 && lo < 30) begin lo++; @(posedge sclk); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL cfg_vect3 queue empty"); end
        else begin e = exp_q.pop_front(); if (vect !== e) begin errors++; $display("FAIL cfg_vect3 got %h exp %h", vect, e); end end
        irq = 1'b0;
        repeat (16) @(posedge sclk);
    endtask

    task automatic test_disable();
        int n; int lo; int lows; logic [7:0] e;
        do_reset();
        irqv = 8'hC3; vect_rdy = 1'b1;
        write_reg(1'b0, 16'h0031);
        irq = 1'b1; exp_q.push_back(8'hC3);
        n = 0;
        while (inta !== 1'b0 && n < 30) begin @(posedge sclk); n++; end
        lo = 0;
        fork
            write_reg(1'b0, 16'h0000);
            begin
                while (inta === 1'b0 && lo < 30) begin lo++; @(posedge sclk); end
            end
        join
        checks++; if (lo != 4) begin errors++; $display("FAIL dis_low_len got %0d exp 4", lo); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL dis_vect queue empty"); end
        else begin e = exp_q.pop_front(); if (vect !== e) begin errors++; $display("FAIL dis_vect got %h exp %h", vect, e); end end
        lows = 0;
        for (int i = 0; i < 40; i++) begin @(posedge sclk); if (inta === 1'b0) lows++; end
        checks++; if (lows != 0) begin errors++; $display("FAIL dis_no_more low cycles got %0d exp 0", lows); end
        checks++; if (dout[12:9] !== 4'h0) begin errors++; $display("FAIL dis_idle enable/state got %h exp 0", dout[12:9]); end
        irq = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        irqv = 8'h99; vect_rdy = 1'b1;
        write_reg(1'b0, 16'h0771);
        irq = 1'b1;
        n = 0;
        while (inta !== 1'b0 && n < 30) begin @(posedge sclk); n++; end
        repeat (3) @(posedge sclk);
        checks++; if (inta !== 1'b0) begin errors++; $display("FAIL rmid_in_assert inta got %b exp 0", inta); end
        nrst = 1'b0;
        #1;
        checks++; if (inta !== 1'b1) begin errors++; $display("FAIL rmid_inta got %b exp 1", inta); end
        checks++; if (vect_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", vect_valid); end
        irq = 1'b0; vect_rdy = 1'b0;
        @(posedge sclk);
        nrst = 1'b1;
        repeat (3) @(posedge sclk);
        checks++; if (dout !== 32'h0 || inta !== 1'b1) begin errors++; $display("FAIL rmid_after dout %h inta %b exp 00000000 1", dout, inta); end
    endtask

`ifdef IRQ_ACK_STATS_EN
    task automatic test_counters();
        int falls; int cyc; logic prev;
        do_reset();
        irqv = 8'h01; vect_rdy = 1'b1;
        write_reg(1'b0, 16'h0001);
        irq = 1'b1;
        falls = 0; cyc = 0; prev = 1'b1;
        while (falls < 258 && cyc < 5000) begin
            @(posedge sclk); cyc++;
            if (prev === 1'b1 && inta === 1'b0) falls++;
            prev = inta;
        end
        checks++; if (falls != 258) begin errors++; $display("FAIL cnt_pulses got %0d exp 258", falls); end
        cyc = 0;
        while (dout[11:9] !== 3'd1 && cyc < 30) begin @(posedge sclk); cyc++; end
        checks++; if (dout[23:16] !== 8'd255) begin errors++; $display("FAIL cnt_saturate got %0d exp 255", dout[23:16]); end
        // clear write timed to land on the ack edge of the next pulse
        pre_wen = 1'b1; pre_wa = 1'b1;
        @(posedge sclk);
        pre_wen = 1'b0; pre_wa = 1'b0;
        checks++; if (inta !== 1'b0) begin errors++; $display("FAIL cnt_clr_align inta got %b exp 0", inta); end
        @(posedge sclk);
        checks++; if (dout[23:16] !== 8'd0) begin errors++; $display("FAIL cnt_clr_inc got %0d exp 0", dout[23:16]); end
        irq = 1'b0;
        repeat (16) @(posedge sclk);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_backpressure();
        test_config_latch();
        test_disable();
        test_reset_mid();
`ifdef IRQ_ACK_STATS_EN
        test_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
